// File: rtl/ramwb_output_delay_if.sv
// Bus bundle between the SDRAM-side response path and the delayed
// wishbone response. The master drives the request/beat side.
interface ramwb_output_delay_if #(
    parameter int dw = 32
);
    logic          en;
    logic          ci;
    logic          bus_cyc_i;
    logic          ram_ack_i;
    logic          ram_err_i;
    logic [dw-1:0] ram_dat_i;
    logic          delayed_ack_o;
    logic          delayed_err_o;
    logic [dw-1:0] delayed_dat_o;
    logic          busy_o;
    logic          overflow_o;

    modport master (
        output en, ci, bus_cyc_i, ram_ack_i, ram_err_i, ram_dat_i,
        input  delayed_ack_o, delayed_err_o, delayed_dat_o,
        input  busy_o, overflow_o
    );

    modport slave (
        input  en, ci, bus_cyc_i, ram_ack_i, ram_err_i, ram_dat_i,
        output delayed_ack_o, delayed_err_o, delayed_dat_o,
        output busy_o, overflow_o
    );
endinterface

// File: rtl/ramwb_output_delay.sv
// Buffers an SDRAM read response (single beat or cache-line burst),
// holds it for delay_cycles, then replays it to the wishbone bus.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//   en/ci/bus_cyc_i and ram_ack/err/dat in; delayed_ack/err/dat,
//   busy_o and sticky overflow_o out. en=0 in IDLE is a bypass.
module ramwb_output_delay #(
    parameter int delay_cycles  = 10,
    parameter int cacheLineSize = 8,
    parameter int dw            = 32
) (
    input logic                 clk,
    input logic                 rst,
    ramwb_output_delay_if.slave bus
);
    localparam int PW    = $clog2(cacheLineSize + 1);
    localparam int DEPTH = 2 ** PW;

    localparam logic [15:0]   DLY = 16'(delay_cycles);
    localparam logic [PW-1:0] CLS = PW'(cacheLineSize);
    localparam logic [PW-1:0] ONE = PW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_REPLAY  = 2'd3;

    logic [1:0]    state_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] exp_q;
    logic [15:0]   cnt_q;
    logic          ack_q;
    logic          err_q;
    logic [dw-1:0] dat_q;
    logic          ovf_q;

    logic [dw-1:0] mem_dat [DEPTH];
    logic          mem_err [DEPTH];

    logic          we;
    logic [PW-1:0] waddr;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic [PW-1:0] exp_new;
    logic          bypass;

    assign wr_nxt  = wr_ptr_q + ONE;
    assign rd_nxt  = rd_ptr_q + ONE;
    assign exp_new = bus.ci ? ONE : CLS;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        case (state_q)
            S_IDLE: begin
                we = bus.en && bus.ram_ack_i;
            end
            S_CAPTURE: begin
                we    = bus.bus_cyc_i && bus.ram_ack_i;
                waddr = wr_ptr_q;
            end
            default: ;
        endcase
    end

    // Beat storage carries no reset; stale contents are never replayed.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_dat[waddr] <= bus.ram_dat_i;
            mem_err[waddr] <= bus.ram_err_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.en && bus.ram_ack_i) begin
                        wr_ptr_q <= ONE;
                        rd_ptr_q <= '0;
                        exp_q    <= exp_new;
                        cnt_q    <= DLY;
                        state_q  <= (exp_new == ONE) ? S_WAIT : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (!bus.bus_cyc_i) begin
                        state_q  <= S_IDLE;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        cnt_q    <= '0;
                    end else if (bus.ram_ack_i) begin
                        wr_ptr_q <= wr_nxt;
                        if (wr_nxt == exp_q) begin
                            cnt_q   <= DLY;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.bus_cyc_i) begin
                        state_q  <= S_IDLE;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        cnt_q    <= '0;
                    end else begin
                        if (bus.ram_ack_i) ovf_q <= 1'b1;
                        if (cnt_q == 16'd0) state_q <= S_REPLAY;
                        else                cnt_q   <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    if (!bus.bus_cyc_i) begin
                        state_q  <= S_IDLE;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        cnt_q    <= '0;
                    end else begin
                        if (bus.ram_ack_i) ovf_q <= 1'b1;
                        // Errored beats take their slot with ack low.
                        ack_q    <= !mem_err[rd_ptr_q];
                        err_q    <= mem_err[rd_ptr_q];
                        dat_q    <= mem_dat[rd_ptr_q];
                        rd_ptr_q <= rd_nxt;
                        if (rd_nxt == exp_q) begin
                            state_q  <= S_IDLE;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    // The last replayed beat is still in the output register during the
    // first IDLE cycle; bypass waits until that beat has been shown.
    assign bypass = (state_q == S_IDLE) && !bus.en && !ack_q && !err_q;

    assign bus.delayed_ack_o = bypass ? bus.ram_ack_i : ack_q;
    assign bus.delayed_err_o = bypass ? bus.ram_err_i : err_q;
    assign bus.delayed_dat_o = bypass ? bus.ram_dat_i : dat_q;
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.overflow_o    = ovf_q;
endmodule
